div_signed_seq: RTL and testbench

//   Sequential signed two's-complement divider; the inverse operation of the combinational signed multiplier.

---
 rtl/div_signed_seq_pkg.sv | 17 +
 rtl/div_signed_seq_if.sv | 27 ++
 rtl/div_signed_seq_twos_negate.sv | 26 ++
 rtl/div_signed_seq.sv | 128 ++++++++++++
 tb/tb_div_signed_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_signed_seq_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// controller state encoding and the divide-by-zero quotient pattern.
package div_signed_seq_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // All-ones quotient reported on divide by zero; sliced to the operand width.
    localparam logic [63:0] DZ_QUOT_ALL = '1;

endpackage

// File: rtl/div_signed_seq_if.sv
// Request/result bundle of the divider: operands and start from the master,
// status and results from the divider.
interface div_signed_seq_if
    import div_signed_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] REM;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, A, B,
        input  busy, done, R, REM, div_zero, overflow
    );

    modport slave (
        input  start, A, B,
        output busy, done, R, REM, div_zero, overflow
    );
endinterface

// File: rtl/div_signed_seq_twos_negate.sv
// Conditional two's-complement negate: y = neg ? -a : a, as an incrementer
// over the optionally inverted operand with carry-in = neg.
module twos_negate
    import div_signed_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] c;

    assign x    = a_i ^ {WIDTH{neg_i}};
    assign c[0] = neg_i;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y_o[gi] = x[gi] ^ c[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign c[gi+1] = x[gi] & c[gi];
            end
        end
    endgenerate
endmodule

// File: rtl/div_signed_seq.sv
// Sequential signed divider: magnitudes are divided by a restoring
// shift/subtract loop (one quotient bit per clock), then sign-corrected.
module div_signed_seq
    import div_signed_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 CLR,
    div_signed_seq_if.slave      bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] quo_q, rem_q, div_q;
    logic             neg_quo_q, neg_rem_q, dz_q, ovf_q;
    logic             busy_q, done_q, div_zero_q, overflow_q;
    logic [WIDTH-1:0] r_q, rem_out_q;

    logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [WIDTH-1:0] quo_d, rem_d, diff;
    logic [WIDTH:0]   trial_a, trial_b;
    logic [WIDTH+1:0] carry;

    twos_negate #(.WIDTH(WIDTH)) u_abs_a (.a_i(bus.A), .neg_i(bus.A[WIDTH-1]), .y_o(abs_a));
    twos_negate #(.WIDTH(WIDTH)) u_abs_b (.a_i(bus.B), .neg_i(bus.B[WIDTH-1]), .y_o(abs_b));
    twos_negate #(.WIDTH(WIDTH)) u_fix_q (.a_i(quo_q), .neg_i(neg_quo_q), .y_o(quo_fix));
    twos_negate #(.WIDTH(WIDTH)) u_fix_r (.a_i(rem_q), .neg_i(neg_rem_q), .y_o(rem_fix));

    // Trial subtract over WIDTH+1 bits; a carry out means no borrow, i.e. keep.
    assign trial_a  = {rem_q, quo_q[WIDTH-1]};
    assign trial_b  = ~{1'b0, div_q};
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
            assign carry[gi+1] = (trial_a[gi] & trial_b[gi]) | (trial_a[gi] & carry[gi])
                               | (trial_b[gi] & carry[gi]);
            if (gi < WIDTH) begin : g_sum
                assign diff[gi] = trial_a[gi] ^ trial_b[gi] ^ carry[gi];
            end
        end
    endgenerate

    assign rem_d = carry[WIDTH+1] ? diff : trial_a[WIDTH-1:0];
    assign quo_d = {quo_q[WIDTH-2:0], carry[WIDTH+1]};

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state_q    <= IDLE;
            count_q    <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            r_q        <= '0;
            rem_out_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        overflow_q <= 1'b0;
                        neg_quo_q  <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        neg_rem_q  <= bus.A[WIDTH-1];
                        div_q      <= abs_b;
                        ovf_q      <= (bus.A == MOST_NEG) && (bus.B == {WIDTH{1'b1}});
                        count_q    <= CW'(WIDTH - 1);
                        if (bus.B == '0) begin
                            // Results are final already, so skip straight to publishing.
                            dz_q    <= 1'b1;
                            quo_q   <= DZ_QUOT_ALL[WIDTH-1:0];
                            rem_q   <= bus.A;
                            state_q <= DONE;
                        end else begin
                            dz_q    <= 1'b0;
                            quo_q   <= abs_a;
                            rem_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    if (count_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                FIX: begin
                    quo_q   <= quo_fix;
                    rem_q   <= rem_fix;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    r_q        <= quo_q;
                    rem_out_q  <= rem_q;
                    div_zero_q <= dz_q;
                    overflow_q <= ovf_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.R        = r_q;
    assign bus.REM      = rem_out_q;
    assign bus.div_zero = div_zero_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_div_signed_seq.sv
// Randomized and directed bench for div_signed_seq against an arithmetic model.
module tb_div_signed_seq;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] rem;
        logic         dz;
        logic         ov;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic CLR = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    exp_t         q[$];
    logic [W-1:0] last_r = '0, last_rem = '0;
    logic         last_dz = 1'b0, last_ov = 1'b0;

    div_signed_seq_if #(.WIDTH(W)) bus ();
    div_signed_seq #(.WIDTH(W)) dut (.clk(clk), .CLR(CLR), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ai, bi, qi, mi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e.dz = 1'b0;
        e.ov = 1'b0;
        e.lat = W + 2;
        e.acc = 0;
        if (bi == 0) begin
            e.r = '1;
            e.rem = a;
            e.dz = 1'b1;
            e.lat = 1;
        end else if (ai == -(2 ** (W - 1)) && bi == -1) begin
            e.r = {1'b1, {(W-1){1'b0}}};
            e.rem = '0;
            e.ov = 1'b1;
        end else begin
            qi = ai / bi;
            mi = ai % bi;
            e.r = qi[W-1:0];
            e.rem = mi[W-1:0];
        end
        return e;
    endfunction

    // Single compare process: results at done, hold/busy on every other cycle.
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        exp_busy = (q.size() > 0) && !bus.done;
        checks++;
        if (bus.busy !== exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy);
        end
        if (bus.done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d got done=1 exp done=0", cyc);
            end else begin
                e = q.pop_front();
                checks++;
                if (bus.R !== e.r || bus.REM !== e.rem || bus.div_zero !== e.dz || bus.overflow !== e.ov) begin
                    errors++;
                    $display("FAIL result got R=%h REM=%h dz=%b ov=%b exp R=%h REM=%h dz=%b ov=%b",
                             bus.R, bus.REM, bus.div_zero, bus.overflow, e.r, e.rem, e.dz, e.ov);
                end
                checks++;
                if (cyc - e.acc != e.lat) begin
                    errors++;
                    $display("FAIL latency got=%0d exp=%0d", cyc - e.acc, e.lat);
                end
                last_r = e.r;
                last_rem = e.rem;
                last_dz = e.dz;
                last_ov = e.ov;
            end
        end else begin
            checks++;
            if (bus.R !== last_r || bus.REM !== last_rem || bus.div_zero !== last_dz || bus.overflow !== last_ov) begin
                errors++;
                $display("FAIL hold cyc=%0d got R=%h REM=%h dz=%b ov=%b exp R=%h REM=%h dz=%b ov=%b", cyc,
                         bus.R, bus.REM, bus.div_zero, bus.overflow, last_r, last_rem, last_dz, last_ov);
            end
        end
    end

    // Called at a negedge with the divider idle.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(a, b);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        last_dz = 1'b0;
        last_ov = 1'b0;
        bus.start = 1'b0;
        bus.A = W'($urandom);
        bus.B = W'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout got no done exp done within 20 cycles");
            q.delete();
        end
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] er, input logic [W-1:0] erem,
                            input logic edz, input logic eov);
        exp_t m;
        m = model(a, b);
        checks++;
        if (m.r !== er || m.rem !== erem || m.dz !== edz || m.ov !== eov) begin
            errors++;
            $display("FAIL model_pin %h/%h got R=%h REM=%h exp R=%h REM=%h", a, b, m.r, m.rem, er, erem);
        end
        launch(a, b);
        wait_done();
        $display("op A=%0d B=%0d R=%0d REM=%0d dz=%b ov=%b", $signed(a), $signed(b),
                 $signed(bus.R), $signed(bus.REM), bus.div_zero, bus.overflow);
    endtask

    initial begin
        logic [W-1:0] a, b;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.R !== '0 || bus.REM !== '0 ||
            bus.div_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b R=%h REM=%h exp all zero",
                     bus.busy, bus.done, bus.R, bus.REM);
        end
        CLR = 1'b1;
        @(negedge clk);

        directed(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        directed(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0);
        directed(8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 1'b0);
        directed(8'h80, 8'd3, 8'hD6, 8'hFE, 1'b0, 1'b0);
        directed(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b0);
        directed(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 1'b1);
        directed(8'd6, 8'd3, 8'd2, 8'd0, 1'b0, 1'b0);

        // start pulse mid-operation must be ignored
        launch(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.A = 8'd1;
        bus.B = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        // reset asserted mid-operation
        launch(8'd77, 8'd5);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        CLR = 1'b0;
        q.delete();
        last_r = '0;
        last_rem = '0;
        last_dz = 1'b0;
        last_ov = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.R !== '0 || bus.REM !== '0) begin
            errors++;
            $display("FAIL clr_abort got busy=%b done=%b R=%h REM=%h exp all zero",
                     bus.busy, bus.done, bus.R, bus.REM);
        end
        repeat (2) @(posedge clk);
        #2;
        CLR = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 15))
                0: b = '0;
                1: b = '1;
                2: a = 8'h80;
                3: begin a = 8'h80; b = '1; end
                default: ;
            endcase
            launch(a, b);
            wait_done();
            if (i % 250 == 0)
                $display("rand %0d A=%0d B=%0d R=%0d REM=%0d", i, $signed(a), $signed(b),
                         $signed(bus.R), $signed(bus.REM));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
